fifo_rd_ctrl: RTL and testbench

Read-side controller of the asynchronous FIFO, living entirely in the read clock domain.
- Owns the binary and Gray read pointers and generates empty_flag from the write pointer already synchronised into the read domain.
- Drives rd_address/rd_inc into fifo_memory.
- Re-times fifo_memory's registered rd_data into a 2-entry valid/ready output stream, so consumers see a standard handshake at 1 word/cycle sustained.

---
 rtl/fifo_rd_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the asynchronous FIFO. Everything here
// runs in the read clock domain.
//   - Keeps the binary and Gray read pointers.
//   - Derives empty_flag and rd_level from the write pointer, which arrives
//     already synchronised into this domain.
//   - Drives rd_address/rd_inc into fifo_memory.
//   - Re-times the registered memory read data into a 2-entry valid/ready
//     output stream that sustains one word per cycle.
//
// Parameters:
//   data_width        word width (matches fifo_memory)
//   addr_width        memory address bits; pointers are addr_width+1 bits
//   almost_empty_thr  only with FIFO_RD_ALMOST_EMPTY_EN; almost_empty threshold
//
// Ports:
//   rd_clk       read clock; all logic on the rising edge
//   rd_rst_n     synchronous active-low reset
//   rq2_wptr     Gray write pointer, synchronised into rd_clk
//   rd_ptr_gray  registered Gray read pointer, for the write domain
//   rd_address   binary read address to fifo_memory
//   rd_inc       read strobe to fifo_memory (combinational)
//   empty_flag   registered empty
//   mem_rd_data  fifo_memory read data, valid the cycle after rd_inc
//   out_data     head word of the output buffer
//   out_valid    out_data valid
//   out_ready    consumer accepts out_data
//   rd_level     words still in memory (excludes buffered/in-flight words)
//   almost_empty only with FIFO_RD_ALMOST_EMPTY_EN; registered,
//                high while rd_level <= almost_empty_thr
//
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN
module fifo_rd_ctrl #(
  parameter int data_width = 8,
  parameter int addr_width = 4
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int almost_empty_thr = 2
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [addr_width:0]   rq2_wptr,
  output logic [addr_width:0]   rd_ptr_gray,
  output logic [addr_width-1:0] rd_address,
  output logic                  rd_inc,
  output logic                  empty_flag,
  input  logic [data_width-1:0] mem_rd_data,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [addr_width:0]   rd_level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty
`endif
);

  localparam int PW = addr_width + 1;

  logic [PW-1:0]         rbin;
  logic [PW-1:0]         rbin_next;
  logic [PW-1:0]         rgray_next;
  logic [PW-1:0]         level_next;
  logic [1:0]            buf_count;
  logic                  inflight;
  logic                  pop;
  logic                  fetch;
  logic [2:0]            space;
  logic [data_width-1:0] buf0;
  logic [data_width-1:0] buf1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Free buffer slots once this cycle's pop is credited. buf_count+inflight
  // never exceeds 2, so this stays within 0..2.
  always_comb begin
    pop        = out_valid && out_ready;
    space      = 3'd2 - {1'b0, buf_count} - {2'b0, inflight} + {2'b0, pop};
    fetch      = !empty_flag && (space != 3'd0);
    rbin_next  = rbin + {{addr_width{1'b0}}, fetch};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    level_next = gray2bin(rq2_wptr) - rbin_next;
  end

  assign rd_inc     = fetch;
  assign rd_address = rbin[addr_width-1:0];
  assign out_data   = buf0;
  assign out_valid  = (buf_count != 2'd0);

  // Stage p0 -> p1: pointer/flag update and memory-read tracking; buffer head.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rbin        <= '0;
      rd_ptr_gray <= '0;
      empty_flag  <= 1'b1;
      rd_level    <= '0;
      inflight    <= 1'b0;
      buf_count   <= 2'd0;
      buf0        <= '0;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      almost_empty <= 1'b1;
`endif
    end else begin
      rbin        <= rbin_next;
      rd_ptr_gray <= rgray_next;
      empty_flag  <= (rgray_next == rq2_wptr);
      rd_level    <= level_next;
      inflight    <= fetch;
      buf_count   <= buf_count + {1'b0, inflight} - {1'b0, pop};
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      almost_empty <= (level_next <= almost_empty_thr[PW-1:0]);
`endif
      // Head advances on pop; a word arriving into a single-entry buffer
      // that is popping the same cycle goes straight to the head.
      if (pop) begin
        if (inflight && buf_count == 2'd1) begin
          buf0 <= mem_rd_data;
        end else begin
          buf0 <= buf1;
        end
      end else if (inflight && buf_count == 2'd0) begin
        buf0 <= mem_rd_data;
      end
    end
  end

  // Stage p1 -> p2: second buffer slot (data only, no reset needed).
  always_ff @(posedge rd_clk) begin
    if (inflight && ((pop && buf_count == 2'd2) || (!pop && buf_count == 2'd1))) begin
      buf1 <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       rd_clk;
  logic       rd_rst_n;
  logic [4:0] rq2_wptr;
  logic [4:0] rd_ptr_gray;
  logic [3:0] rd_address;
  logic       rd_inc;
  logic       empty_flag;
  logic [7:0] mem_rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] rd_level;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  logic [7:0] mem [16];
  logic [7:0] sb [$];
  int         n_pass;
  int         n_total;

  fifo_rd_ctrl #(.data_width(8), .addr_width(4)) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .rq2_wptr    (rq2_wptr),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_address  (rd_address),
    .rd_inc      (rd_inc),
    .empty_flag  (empty_flag),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    .almost_empty(almost_empty),
`endif
    .rd_level    (rd_level)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Behavioural fifo_memory read port: registered data on rd_inc.
  always @(posedge rd_clk) begin
    if (rd_inc) mem_rd_data <= mem[rd_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset;
    rd_rst_n  = 1'b0;
    rq2_wptr  = '0;
    out_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    rd_rst_n = 1'b1;
  endtask

  // Monitor: every accepted output word must match the next expected word.
  always @(negedge rd_clk) begin
    if (rd_rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %0h expected no word", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_pass      = 0;
    n_total     = 0;
    mem_rd_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);

    // Reset, then idle with an empty write side.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_empty",  32'(empty_flag),  32'd1);
      chk("idle_rd_inc", 32'(rd_inc),      32'd0);
      chk("idle_valid",  32'(out_valid),   32'd0);
      chk("idle_level",  32'(rd_level),    32'd0);
      chk("idle_gray",   32'(rd_ptr_gray), 32'd0);
    end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("idle_almost_empty", 32'(almost_empty), 32'd1);
`endif

    // Single word.
    out_ready = 1'b1;
    rq2_wptr  = gray(1);
    sb.push_back(8'h10);
    tick();
    chk("w1_empty",   32'(empty_flag), 32'd0);
    chk("w1_rd_inc",  32'(rd_inc),     32'd1);
    chk("w1_addr",    32'(rd_address), 32'd0);
    chk("w1_level",   32'(rd_level),   32'd1);
    tick();
    chk("w1_empty2",  32'(empty_flag),  32'd1);
    chk("w1_gray",    32'(rd_ptr_gray), 32'd1);
    chk("w1_rd_inc2", 32'(rd_inc),      32'd0);
    chk("w1_level2",  32'(rd_level),    32'd0);
    tick();
    chk("w1_valid",   32'(out_valid), 32'd1);
    chk("w1_data",    32'(out_data),  32'h10);
    tick();
    chk("w1_valid_off", 32'(out_valid), 32'd0);

    // 16 words, consumer always ready.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    out_ready = 1'b1;
    rq2_wptr  = 5'b11000;
    for (int i = 0; i < 16; i++) sb.push_back(8'(8'h40 + i));
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k <= 16) begin
        chk("f16_rd_inc", 32'(rd_inc),     32'd1);
        chk("f16_addr",   32'(rd_address), 32'(k - 1));
      end
      if (k >= 3 && k <= 18) chk("f16_valid", 32'(out_valid), 32'd1);
    end
    chk("f16_rd_inc_end", 32'(rd_inc),      32'd0);
    chk("f16_valid_end",  32'(out_valid),   32'd0);
    chk("f16_empty_end",  32'(empty_flag),  32'd1);
    chk("f16_gray_end",   32'(rd_ptr_gray), 32'b11000);
    chk("f16_level_end",  32'(rd_level),    32'd0);
    chk("f16_sb_drained", 32'(sb.size()),   32'd0);

    // 16 words under backpressure, then drain.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h80 + i);
    rq2_wptr = 5'b11000;
    for (int i = 0; i < 16; i++) sb.push_back(8'(8'h80 + i));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rd_inc) cnt++;
    end
    chk("bp_fetches", 32'(cnt),       32'd2);
    chk("bp_valid",   32'(out_valid), 32'd1);
    chk("bp_data",    32'(out_data),  32'h80);
    chk("bp_level",   32'(rd_level),  32'd14);
    chk("bp_rd_inc",  32'(rd_inc),    32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("bp_almost_empty", 32'(almost_empty), 32'd0);
`endif
    out_ready = 1'b1;
    repeat (20) tick();
    chk("bp_sb_drained", 32'(sb.size()),  32'd0);
    chk("bp_empty_end",  32'(empty_flag), 32'd1);
    chk("bp_valid_end",  32'(out_valid),  32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("bp_almost_empty_end", 32'(almost_empty), 32'd1);
`endif

    // Wrap-around: 16 words, then 4 more at addresses 0..3.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hC0 + i);
    out_ready = 1'b1;
    rq2_wptr  = 5'b11000;
    for (int i = 0; i < 16; i++) sb.push_back(8'(8'hC0 + i));
    repeat (22) tick();
    chk("wr_gray16", 32'(rd_ptr_gray), 32'b11000);
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'hE0 + i);
    rq2_wptr = gray(20);
    for (int i = 0; i < 4; i++) sb.push_back(8'(8'hE0 + i));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wr_rd_inc", 32'(rd_inc),     32'd1);
      chk("wr_addr",   32'(rd_address), 32'(k - 1));
    end
    repeat (6) tick();
    chk("wr_gray20",   32'(rd_ptr_gray), 32'b11110);
    chk("wr_addr_end", 32'(rd_address),  32'd4);
    chk("wr_empty",    32'(empty_flag),  32'd1);
    chk("wr_sb",       32'(sb.size()),   32'd0);

    // Reset while words are buffered and a read is in flight.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + i);
    rq2_wptr = 5'b11000;
    for (int i = 0; i < 16; i++) sb.push_back(8'(8'h30 + i));
    tick();
    tick();
    tick();
    chk("mr_valid_before", 32'(out_valid), 32'd1);
    rd_rst_n = 1'b0;
    rq2_wptr = '0;
    sb.delete();
    tick();
    chk("mr_valid",  32'(out_valid),   32'd0);
    chk("mr_empty",  32'(empty_flag),  32'd1);
    chk("mr_gray",   32'(rd_ptr_gray), 32'd0);
    chk("mr_addr",   32'(rd_address),  32'd0);
    chk("mr_level",  32'(rd_level),    32'd0);
    rd_rst_n  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mr_no_stale", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
